shiftreg_tx_ctrl: RTL and testbench

- Sequencer for the team's 8-bit load/shift register, whose control is a single select: S=1 parallel-loads p_in and S=0 shifts s_in in.
- Accepts bytes over a valid/ready handshake and loads each byte into the register.
- Clocks the byte out bit by bit on a valid/ready serial port, using load-feedback to stall the register.
- Sits between a byte producer and a serial consumer; the register instance stays external and is driven through the sr_* ports.

---
 rtl/shiftreg_pkg.sv | 17 +
 rtl/shiftreg_tx_ctrl.sv | 107 ++++++++++
 tb/tb_shiftreg_tx_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/shiftreg_pkg.sv
// Shared definitions for the load/shift register sequencer: state encoding,
// register select encoding and the default byte width.
package shiftreg_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;

    localparam logic SR_LOAD  = 1'b1;
    localparam logic SR_SHIFT = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/shiftreg_tx_ctrl.sv
// Byte-to-serial sequencer driving an external load/shift register: loads each
// accepted byte, then clocks it out over a valid/ready serial port.
module shiftreg_tx_ctrl
    import shiftreg_pkg::*;
#(
    parameter int unsigned DATA_W     = DEFAULT_DATA_W,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned GAP_CYCLES = 2,
    parameter logic        FILL       = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              sr_S,
    output logic              sr_s_in,
    output logic [DATA_W-1:0] sr_p_in,
    input  logic [DATA_W-1:0] sr_q,
    output logic              ser_out,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W    = $clog2(DATA_W) + 1;
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int unsigned OUT_BIT  = MSB_FIRST ? DATA_W - 1 : 0;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [DATA_W-1:0] hold_q;
    logic              stall;

    // A stalled shift reloads the register with its own contents so it holds.
    assign stall   = (state == SHIFT) && !ser_ready;
    assign sr_S    = ((state == LOAD) || stall) ? SR_LOAD : SR_SHIFT;
    assign sr_p_in = stall ? sr_q : hold_q;
    assign sr_s_in = FILL;
    assign ser_out = ser_valid ? sr_q[OUT_BIT] : FILL;

    // Sequencer; in_ready/ser_valid/busy are registered with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            gap_cnt   <= '0;
            hold_q    <= '0;
            in_ready  <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        hold_q   <= in_data;
                        state    <= LOAD;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    state     <= SHIFT;
                    cnt       <= '0;
                    ser_valid <= 1'b1;
                end
                SHIFT: begin
                    if (ser_ready) begin
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            done      <= 1'b1;
                            ser_valid <= 1'b0;
                            cnt       <= '0;
                            if (GAP_CYCLES == 0) begin
                                state    <= IDLE;
                                in_ready <= 1'b1;
                                busy     <= 1'b0;
                            end else begin
                                state   <= GAP;
                                gap_cnt <= '0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_LAST)) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shiftreg_tx_ctrl.sv
// Bench for shiftreg_tx_ctrl: an MSB-first unit (2 gap cycles) and an LSB-first
// unit (no gap), each driving its own behavioural 8-bit load/shift register.
module tb_shiftreg_tx_ctrl;

    localparam int unsigned W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in_valid, in_ready, sr_S, sr_s_in, ser_out, ser_valid, ser_ready, busy, done;
    logic [W-1:0] in_data [2];
    logic [W-1:0] sr_p_in [2];
    logic [W-1:0] sr_q    [2];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shiftreg_tx_ctrl #(.DATA_W(W), .MSB_FIRST(1'b1), .GAP_CYCLES(2), .FILL(1'b0)) u_msb (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .sr_S(sr_S[0]), .sr_s_in(sr_s_in[0]), .sr_p_in(sr_p_in[0]), .sr_q(sr_q[0]),
        .ser_out(ser_out[0]), .ser_valid(ser_valid[0]), .ser_ready(ser_ready[0]),
        .busy(busy[0]), .done(done[0])
    );

    shiftreg_tx_ctrl #(.DATA_W(W), .MSB_FIRST(1'b0), .GAP_CYCLES(0), .FILL(1'b0)) u_lsb (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .sr_S(sr_S[1]), .sr_s_in(sr_s_in[1]), .sr_p_in(sr_p_in[1]), .sr_q(sr_q[1]),
        .ser_out(ser_out[1]), .ser_valid(ser_valid[1]), .ser_ready(ser_ready[1]),
        .busy(busy[1]), .done(done[1])
    );

    // Plant registers: S=1 loads p_in, S=0 shifts s_in in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q[0] <= '0;
            sr_q[1] <= '0;
        end else begin
            sr_q[0] <= sr_S[0] ? sr_p_in[0] : {sr_q[0][W-2:0], sr_s_in[0]};
            sr_q[1] <= sr_S[1] ? sr_p_in[1] : {sr_s_in[1], sr_q[1][W-1:1]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the bit sent i-th and the register image after i shifts.
    function automatic logic exp_bit(input logic [7:0] b, input int i, input bit msb);
        return msb ? b[7 - i] : b[i];
    endfunction

    function automatic logic [7:0] exp_q(input logic [7:0] b, input int n, input bit msb);
        return msb ? (b << n) : (b >> n);
    endfunction

    task automatic chk_reset(input int u);
        chk("rst_in_ready",  32'(in_ready[u]),  0);
        chk("rst_sr_S",      32'(sr_S[u]),      0);
        chk("rst_sr_s_in",   32'(sr_s_in[u]),   0);
        chk("rst_sr_p_in",   32'(sr_p_in[u]),   0);
        chk("rst_ser_valid", 32'(ser_valid[u]), 0);
        chk("rst_ser_out",   32'(ser_out[u]),   0);
        chk("rst_busy",      32'(busy[u]),      0);
        chk("rst_done",      32'(done[u]),      0);
    endtask

    // One byte on unit u; starts and ends at a sample point (negedge + 1).
    task automatic xfer(input int u, input logic [7:0] b, input int stall_bit, input int stall_len,
                        input bit rnd, input bit keep, input bit b2b, output int shift_n);
        int  wait_n, nbits, stalls, first_v, last_v, done_cyc, ndone, ready_cyc, stall_left, gap;
        bit  msb;
        msb = (u == 0);
        gap = (u == 0) ? 2 : 0;
        nbits = 0; stalls = 0; shift_n = 0; ndone = 0;
        first_v = -1; last_v = -1; done_cyc = -1; ready_cyc = -1;
        stall_left = stall_len;
        wait_n = 0;
        in_valid[u] = 1'b1;
        in_data[u]  = b;
        while (!in_ready[u] && wait_n < 40) begin
            @(negedge clk); #1;
            wait_n++;
        end
        chk("ready_timeout", 32'(in_ready[u]), 1);
        if (b2b) chk("b2b_accept_wait", wait_n, 0);
        for (int cyc = 1; cyc <= 60 && ready_cyc < 0; cyc++) begin
            @(negedge clk);
            if (!keep) begin
                if (cyc == 1) in_valid[u] = 1'b0;
                if (cyc == 4) begin in_valid[u] = 1'b1; in_data[u] = ~b; end
                if (cyc == 5) in_valid[u] = 1'b0;
            end
            if (rnd) ser_ready[u] = ($urandom_range(3) != 0);
            else     ser_ready[u] = !(nbits == stall_bit && stall_left > 0);
            #1;
            if (ser_valid[u]) begin
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                shift_n++;
                chk("in_ready_in_shift", 32'(in_ready[u]), 0);
                if (nbits < 8) begin
                    chk("ser_out", 32'(ser_out[u]), 32'(exp_bit(b, nbits, msb)));
                    chk("sr_q", 32'(sr_q[u]), 32'(exp_q(b, nbits, msb)));
                    if (ser_ready[u]) begin
                        chk("sr_S_shift", 32'(sr_S[u]), 0);
                        chk("sr_p_in_hold", 32'(sr_p_in[u]), 32'(b));
                        nbits++;
                    end else begin
                        chk("sr_S_stall", 32'(sr_S[u]), 1);
                        chk("sr_p_in_stall", 32'(sr_p_in[u]), 32'(exp_q(b, nbits, msb)));
                        stalls++;
                        if (stall_left > 0) stall_left--;
                    end
                end else begin
                    chk("extra_bit", nbits, 7);
                end
            end
            if (done[u]) begin
                ndone++;
                done_cyc = cyc;
            end
            if (nbits >= 8 && in_ready[u]) begin
                ready_cyc = cyc;
                chk("busy_idle", 32'(busy[u]), 0);
            end else begin
                chk("busy_active", 32'(busy[u]), 1);
            end
        end
        ser_ready[u] = 1'b1;
        chk("first_bit_latency", first_v, 2);
        chk("bits_delivered", nbits, 8);
        chk("shift_cycles", shift_n, 8 + stalls);
        if (!rnd) chk("stall_cycles", stalls, (stall_bit < 8) ? stall_len : 0);
        chk("done_count", ndone, 1);
        chk("done_cycle", done_cyc, last_v + 1);
        chk("ready_return", ready_cyc, last_v + gap + 1);
    endtask

    initial begin
        int  sc;
        int  nb;
        bit  reached;
        logic [7:0] rb;

        rst          = 1'b1;
        in_valid     = '0;
        ser_ready    = '1;
        in_data[0]   = '0;
        in_data[1]   = '0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset(0);
        chk_reset(1);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("ready_after_init", 32'(in_ready), 32'(2'b11));

        xfer(0, 8'h55, 99, 0, 1'b0, 1'b0, 1'b0, sc);
        xfer(0, 8'hA3, 2, 3, 1'b0, 1'b0, 1'b0, sc);
        chk("stall_shift_total", sc, 11);

        xfer(1, 8'hFF, 99, 0, 1'b0, 1'b1, 1'b0, sc);
        xfer(1, 8'h00, 99, 0, 1'b0, 1'b0, 1'b1, sc);
        xfer(1, 8'h01, 99, 0, 1'b0, 1'b0, 1'b0, sc);

        // Abort 8'hC3 while its bit 4 is on the wire.
        in_valid[0] = 1'b1;
        in_data[0]  = 8'hC3;
        nb = 0;
        reached = 1'b0;
        for (int cyc = 1; cyc <= 30 && !reached; cyc++) begin
            @(negedge clk);
            in_valid[0] = 1'b0;
            #1;
            if (ser_valid[0]) begin
                if (nb == 4) reached = 1'b1;
                else nb++;
            end
        end
        chk("abort_reached_bit4", 32'(reached), 1);
        chk("abort_bit4_value", 32'(ser_out[0]), 0);
        rst = 1'b1;
        #1;
        chk_reset(0);
        repeat (2) begin
            @(negedge clk); #1;
            chk("abort_no_done_rst", 32'(done[0]), 0);
        end
        rst = 1'b0;
        chk("abort_ready_low", 32'(in_ready[0]), 0);
        repeat (4) begin
            @(negedge clk); #1;
            chk("abort_no_done_after", 32'(done[0]), 0);
        end
        xfer(0, 8'h81, 99, 0, 1'b0, 1'b0, 1'b0, sc);

        for (int k = 0; k < 12; k++) begin
            rb = 8'($urandom);
            xfer(k % 2, rb, 99, 0, 1'b1, 1'b0, 1'b0, sc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
